// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the sign-less single-precision
// arithmetic pipes (exponent constants, operand layout, exponent type).
package fp_pkg;

   localparam int FP_EXP_BIAS = 127;
   localparam int FP_EXP_MAX  = 255;

   localparam logic [30:0] FP_QNAN = 31'h7FC00000;
   localparam logic [30:0] FP_INF  = 31'h7F800000;

   // Sign-less IEEE-754 single-precision word.
   typedef struct packed {
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp31_t;

   // Signed exponent wide enough for ea + eb - bias plus normalize/round carries.
   typedef logic signed [9:0] fp_exp_t;

endpackage

// File: rtl/fp_round_pack.sv
// Combinational round, range check and pack of a normalized mantissa.
// Build option: FP_MUL_RNE_EN selects round-to-nearest-even; otherwise the
// result is truncated (round toward zero) and the remainder is ignored.
module fp_round_pack
   import fp_pkg::*;
(
   input  logic               special_in,
   input  logic               zero_in,
   input  logic [22:0]        m_in,
   input  logic [23:0]        r_in,
   input  logic signed [9:0]  e_in,
   output logic [30:0]        y,
   output logic               err
);

`ifdef FP_MUL_RNE_EN
   localparam logic RNE_EN = 1'b1;
`else
   localparam logic RNE_EN = 1'b0;
`endif

   logic        round_up;
   logic [23:0] m_sum;
   logic        carry;
   fp_exp_t     e_rnd;
   fp31_t       packed_y;

   // Rounding increment; a carry out of the fraction bumps the exponent.
   always_comb begin
      round_up = RNE_EN && ((r_in > 24'h800000) || ((r_in == 24'h800000) && m_in[0]));
      m_sum    = {1'b0, m_in} + {23'd0, round_up};
      carry    = m_sum[23];
      e_rnd    = e_in + fp_exp_t'({9'd0, carry});
      packed_y.exp  = e_rnd[7:0];
      packed_y.frac = carry ? 23'd0 : m_sum[22:0];
   end

   // Result selection: specials, zeros, overflow, underflow, then normal.
   always_comb begin
      y   = packed_y;
      err = 1'b0;
      if (special_in) begin
         y   = FP_QNAN;
         err = 1'b1;
      end else if (zero_in) begin
         y   = 31'd0;
      end else if (e_rnd >= fp_exp_t'(FP_EXP_MAX)) begin
         y   = FP_INF;
         err = 1'b1;
      end else if (e_rnd <= 10'sd0) begin
         y   = 31'd0;
      end
   end

endmodule

// File: rtl/fp_mul_newton_pipe.sv
// Pipelined sign-less single-precision multiplier closing a Newton-Raphson
// step of the inverse-square-root datapath (y_next = y * (1.5 - h)).
// Stages: unpack -> 24x24 product -> normalize -> round/pack into outputs.
// A sample sampled at edge N is presented with ready_out=1 after edge N+3.
// Build option: FP_MUL_RNE_EN (round-to-nearest-even, see fp_round_pack).
module fp_mul_newton_pipe
   import fp_pkg::*;
#(
   parameter int TAG_W = 1
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [30:0]      a_in,
   input  logic [30:0]      b_in,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             error_in,
   output logic [30:0]      y_out,
   output logic [TAG_W-1:0] tag_out,
   output logic             ready_out,
   output logic             error_out
);

   // Sideband carried alongside the data: index 0 = unpack, 1 = product, 2 = normalize.
   logic [2:0]       sb_valid_reg;
   logic [2:0]       sb_err_reg;
   logic [TAG_W-1:0] sb_tag_reg [3];

   fp31_t       a_op;
   fp31_t       b_op;
   logic [23:0] ma_next;
   logic [23:0] mb_next;
   fp_exp_t     e_next;
   logic        special_next;
   logic        zero_next;

   logic [23:0] u_ma_reg;
   logic [23:0] u_mb_reg;
   fp_exp_t     u_e_reg;
   logic        u_special_reg;
   logic        u_zero_reg;

   logic [47:0] p_prod_reg;
   fp_exp_t     p_e_reg;
   logic        p_special_reg;
   logic        p_zero_reg;

   logic [22:0] n_m_next;
   logic [23:0] n_r_next;
   fp_exp_t     n_e_next;
   logic [22:0] n_m_reg;
   logic [23:0] n_r_reg;
   fp_exp_t     n_e_reg;
   logic        n_special_reg;
   logic        n_zero_reg;

   logic [30:0] rp_y;
   logic        rp_err;

   assign a_op = a_in;
   assign b_op = b_in;

   // Unpack: classify operands, restore hidden bit, form biased exponent sum.
   always_comb begin
      special_next = (a_op.exp == 8'(FP_EXP_MAX)) || (b_op.exp == 8'(FP_EXP_MAX));
      zero_next    = (a_op.exp == 8'd0) || (b_op.exp == 8'd0);
      ma_next      = {|a_op.exp, a_op.frac};
      mb_next      = {|b_op.exp, b_op.frac};
      e_next       = fp_exp_t'({2'b00, a_op.exp}) + fp_exp_t'({2'b00, b_op.exp})
                     - fp_exp_t'(FP_EXP_BIAS);
   end

   // Sideband shift: valid, tag and error move one stage per cycle; error on a bubble is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb_valid_reg <= 3'd0;
         sb_err_reg   <= 3'd0;
         for (int i = 0; i < 3; i++) begin
            sb_tag_reg[i] <= '0;
         end
      end else begin
         sb_valid_reg  <= {sb_valid_reg[1:0], valid_in};
         sb_err_reg    <= {sb_err_reg[1:0], valid_in & error_in};
         sb_tag_reg[0] <= tag_in;
         sb_tag_reg[1] <= sb_tag_reg[0];
         sb_tag_reg[2] <= sb_tag_reg[1];
      end
   end

   // Unpack stage register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         u_ma_reg      <= 24'd0;
         u_mb_reg      <= 24'd0;
         u_e_reg       <= '0;
         u_special_reg <= 1'b0;
         u_zero_reg    <= 1'b0;
      end else begin
         u_ma_reg      <= ma_next;
         u_mb_reg      <= mb_next;
         u_e_reg       <= e_next;
         u_special_reg <= special_next;
         u_zero_reg    <= zero_next;
      end
   end

   // Product stage register: full 48-bit mantissa product.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_prod_reg    <= 48'd0;
         p_e_reg       <= '0;
         p_special_reg <= 1'b0;
         p_zero_reg    <= 1'b0;
      end else begin
         p_prod_reg    <= {24'd0, u_ma_reg} * {24'd0, u_mb_reg};
         p_e_reg       <= u_e_reg;
         p_special_reg <= u_special_reg;
         p_zero_reg    <= u_zero_reg;
      end
   end

   // Normalize: product of two [1,2) mantissas lies in [1,4); shift by one if >= 2.
   always_comb begin
      n_m_next = p_prod_reg[45:23];
      n_r_next = {p_prod_reg[22:0], 1'b0};
      n_e_next = p_e_reg;
      if (p_prod_reg[47]) begin
         n_m_next = p_prod_reg[46:24];
         n_r_next = p_prod_reg[23:0];
         n_e_next = p_e_reg + 10'sd1;
      end
   end

   // Normalize stage register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_m_reg       <= 23'd0;
         n_r_reg       <= 24'd0;
         n_e_reg       <= '0;
         n_special_reg <= 1'b0;
         n_zero_reg    <= 1'b0;
      end else begin
         n_m_reg       <= n_m_next;
         n_r_reg       <= n_r_next;
         n_e_reg       <= n_e_next;
         n_special_reg <= p_special_reg;
         n_zero_reg    <= p_zero_reg;
      end
   end

   fp_round_pack u_round_pack (
      .special_in (n_special_reg),
      .zero_in    (n_zero_reg),
      .m_in       (n_m_reg),
      .r_in       (n_r_reg),
      .e_in       (n_e_reg),
      .y          (rp_y),
      .err        (rp_err)
   );

   // Output register: strobe ready per sample; data and flags hold between samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_out <= 1'b0;
         y_out     <= 31'd0;
         tag_out   <= '0;
         error_out <= 1'b0;
      end else begin
         ready_out <= sb_valid_reg[2];
         if (sb_valid_reg[2]) begin
            y_out     <= rp_y;
            tag_out   <= sb_tag_reg[2];
            error_out <= sb_err_reg[2] | rp_err;
         end
      end
   end

endmodule

// File: tb/tb_fp_mul_newton_pipe.sv
// Self-checking bench for fp_mul_newton_pipe: directed vectors, an error/tag
// stream with bubbles, randomized traffic against a reference model, and a
// mid-stream asynchronous reset. Honors FP_MUL_RNE_EN like the design.
module tb_fp_mul_newton_pipe;

   localparam int TAG_W = 4;

`ifdef FP_MUL_RNE_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             valid_in;
   logic [30:0]      a_in;
   logic [30:0]      b_in;
   logic [TAG_W-1:0] tag_in;
   logic             error_in;
   logic [30:0]      y_out;
   logic [TAG_W-1:0] tag_out;
   logic             ready_out;
   logic             error_out;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [30:0] y;
      logic        err;
      logic [3:0]  tag;
      int          due;
   } exp_t;

   exp_t exp_q[$];

   fp_mul_newton_pipe #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .a_in      (a_in),
      .b_in      (b_in),
      .tag_in    (tag_in),
      .error_in  (error_in),
      .y_out     (y_out),
      .tag_out   (tag_out),
      .ready_out (ready_out),
      .error_out (error_out)
   );

   always #5 clk = ~clk;

   // Reference: exact integer mantissa product, then the rounding/range rules. Returns {err, y}.
   function automatic logic [31:0] ref_mul(logic [30:0] a, logic [30:0] b);
      int     ea, eb, e;
      longint p, sig, r;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (ea == 255 || eb == 255) return {1'b1, 31'h7FC00000};
      if (ea == 0 || eb == 0) return 32'd0;
      p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
      e = ea + eb - 127;
      if (p >= 64'h8000_0000_0000) begin
         sig = p >> 24;
         r   = p & 64'hFF_FFFF;
         e   = e + 1;
      end else begin
         sig = p >> 23;
         r   = (p & 64'h7F_FFFF) << 1;
      end
      if (RNE && ((r > 64'h80_0000) || (r == 64'h80_0000 && sig[0]))) sig = sig + 1;
      if (sig == 64'h100_0000) begin
         sig = 64'h80_0000;
         e   = e + 1;
      end
      if (e >= 255) return {1'b1, 31'h7F800000};
      if (e <= 0) return 32'd0;
      return {1'b0, 8'(e), 23'(sig)};
   endfunction

   function automatic logic [30:0] rand_op();
      int sel;
      logic [7:0] ex;
      sel = $urandom_range(0, 15);
      case (sel)
         0:       ex = 8'd0;
         1:       ex = 8'd255;
         2, 3:    ex = 8'($urandom_range(190, 254));
         4, 5:    ex = 8'($urandom_range(1, 64));
         default: ex = 8'($urandom_range(100, 154));
      endcase
      return {ex, 23'($urandom)};
   endfunction

   task automatic check(string nm, logic [31:0] obs, logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", nm, obs, expv);
      end
   endtask

   // One clock of traffic: drive at negedge, score outputs 1 time unit after posedge.
   task automatic step(logic v, logic [30:0] a, logic [30:0] b, logic [3:0] t, logic e);
      exp_t x;
      logic [31:0] r;
      @(negedge clk);
      valid_in = v;
      a_in     = a;
      b_in     = b;
      tag_in   = t;
      error_in = e;
      @(posedge clk);
      cyc++;
      if (v && rst) begin
         r     = ref_mul(a, b);
         x.y   = r[30:0];
         x.err = r[31] | e;
         x.tag = t;
         x.due = cyc + 3;
         exp_q.push_back(x);
      end
      #1;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         x = exp_q.pop_front();
         $display("cyc=%0d out tag=%0d y=%h err=%0d", cyc, tag_out, y_out, error_out);
         check("stream_ready", 32'(ready_out), 32'd1);
         check("stream_y", 32'(y_out), 32'(x.y));
         check("stream_err", 32'(error_out), 32'(x.err));
         check("stream_tag", 32'(tag_out), 32'(x.tag));
      end else begin
         check("stream_idle", 32'(ready_out), 32'd0);
      end
   endtask

   // Single isolated sample with explicit expected result and exact latency check.
   task automatic directed(string nm, logic [30:0] a, logic [30:0] b, logic [30:0] ey, logic ee);
      @(negedge clk);
      valid_in = 1'b1;
      a_in     = a;
      b_in     = b;
      tag_in   = 4'h5;
      error_in = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      valid_in = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         if (k < 3) begin
            check({nm, "_early"}, 32'(ready_out), 32'd0);
         end else begin
            $display("%s: %h x %h -> y=%h err=%0d", nm, a, b, y_out, error_out);
            check({nm, "_ready"}, 32'(ready_out), 32'd1);
            check({nm, "_y"}, 32'(y_out), 32'(ey));
            check({nm, "_err"}, 32'(error_out), 32'(ee));
            check({nm, "_tag"}, 32'(tag_out), 32'h5);
         end
      end
      @(posedge clk);
      #1;
      check({nm, "_strobe"}, 32'(ready_out), 32'd0);
   endtask

   initial begin
      rst      = 1'b0;
      valid_in = 1'b0;
      a_in     = '0;
      b_in     = '0;
      tag_in   = '0;
      error_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready_out), 32'd0);
      check("rst_y", 32'(y_out), 32'd0);
      check("rst_tag", 32'(tag_out), 32'd0);
      check("rst_err", 32'(error_out), 32'd0);
      rst = 1'b1;

      directed("one_x_one", 31'h3F800000, 31'h3F800000, 31'h3F800000, 1'b0);
      directed("1p5_x_2", 31'h3FC00000, 31'h40000000, 31'h40400000, 1'b0);
`ifdef FP_MUL_RNE_EN
      directed("tie_round", 31'h3FC00000, 31'h3F800001, 31'h3FC00002, 1'b0);
`else
      directed("tie_round", 31'h3FC00000, 31'h3F800001, 31'h3FC00001, 1'b0);
`endif
      directed("overflow", 31'h7F000000, 31'h7F000000, 31'h7F800000, 1'b1);
      directed("qnan_op", 31'h7FC00000, 31'h3F800000, 31'h7FC00000, 1'b1);
      directed("underflow", 31'h00800000, 31'h00800000, 31'h00000000, 1'b0);
      directed("zero_op", 31'h00000000, 31'h40000000, 31'h00000000, 1'b0);

      // Error/tag stream: 10 samples with bubbles; bubbles carry error_in=1 that must be ignored.
      for (int i = 0; i < 10; i++) begin
         step(1'b1, {8'($urandom_range(110, 140)), 23'($urandom)},
              {8'($urandom_range(110, 140)), 23'($urandom)}, 4'(i), (i == 4));
         step(1'b0, 31'($urandom), 31'($urandom), 4'hF, 1'b1);
      end
      repeat (4) step(1'b0, 31'd0, 31'd0, 4'h0, 1'b0);

      // Randomized traffic with random bubbles and error flags.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 3) != 0), rand_op(), rand_op(), 4'($urandom),
              ($urandom_range(0, 7) == 0));
      end
      repeat (4) step(1'b0, 31'd0, 31'd0, 4'h0, 1'b0);

      // Mid-stream asynchronous reset between clock edges.
      for (int i = 0; i < 6; i++) begin
         step(1'b1, rand_op(), rand_op(), 4'(i), 1'b0);
      end
      #2;
      rst = 1'b0;
      #1;
      check("midrst_ready", 32'(ready_out), 32'd0);
      check("midrst_y", 32'(y_out), 32'd0);
      check("midrst_tag", 32'(tag_out), 32'd0);
      check("midrst_err", 32'(error_out), 32'd0);
      exp_q.delete();
      step(1'b1, 31'h3F800000, 31'h3F800000, 4'h1, 1'b0);
      step(1'b0, 31'd0, 31'd0, 4'h0, 1'b0);
      rst = 1'b1;
      repeat (4) step(1'b0, 31'd0, 31'd0, 4'h0, 1'b0);
      step(1'b1, 31'h3FC00000, 31'h40000000, 4'h7, 1'b0);
      repeat (5) step(1'b0, 31'd0, 31'd0, 4'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
